// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, fixed 32-cycle latency.
// In: clk, reset (async, active-low), start, funct3, rs1_data, rs2_data, rd_in.
// Out: busy, done, wr_en (= done), rd_out, result.
// Define MULDIV_DIV_EN to build the divider; otherwise funct3 1xx returns 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] p_q, p_nxt, prod;
  logic              neg_q;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   res_fin;
  logic              last;
`ifdef MULDIV_DIV_EN
  logic              neg_r, dz;
  logic [XLEN:0]     r_sh;
  logic [XLEN-1:0]   r_sub;
  logic              ge;
`endif

  assign last = (state_q == BUSY) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = done;

  // Operands are reduced to magnitudes; the sign is reapplied at the end.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = rs1_data[XLEN-1];
        b_sgn = rs2_data[XLEN-1];
      end
      3'b010:  a_sgn = rs1_data[XLEN-1];
      default: ;
    endcase
    a_mag = a_sgn ? -rs1_data : rs1_data;
    b_mag = b_sgn ? -rs2_data : rs2_data;
  end

  // p_q: {acc, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    sum   = {1'b0, p_q[2*XLEN-1:XLEN]}
          + (p_q[0] ? {1'b0, m_q} : '0);
    p_nxt = {sum, p_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    r_sh  = p_q[2*XLEN-1:XLEN-1];
    ge    = r_sh >= {1'b0, m_q};
    r_sub = r_sh[XLEN-1:0] - m_q;
    if (op_q[2])
      p_nxt = {ge ? r_sub : r_sh[XLEN-1:0],
               p_q[XLEN-2:0], ge};
`endif
  end

  always_comb begin
    prod    = neg_q ? -p_nxt : p_nxt;
    res_fin = (op_q == 3'b000) ? prod[XLEN-1:0]
                               : prod[2*XLEN-1:XLEN];
    if (op_q[2]) begin
`ifdef MULDIV_DIV_EN
      if (op_q[1])
        res_fin = neg_r ? -p_nxt[2*XLEN-1:XLEN]
                        : p_nxt[2*XLEN-1:XLEN];
      else if (dz)
        res_fin = '1;
      else
        res_fin = neg_q ? -p_nxt[XLEN-1:0]
                        : p_nxt[XLEN-1:0];
`else
      res_fin = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      m_q    <= '0;
      p_q    <= '0;
      neg_q  <= 1'b0;
      rd_out <= '0;
      result <= '0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cnt_q  <= '0;
          op_q   <= funct3;
          rd_out <= rd_in;
          m_q    <= funct3[2] ? b_mag : a_mag;
          p_q    <= {{XLEN{1'b0}},
                     funct3[2] ? a_mag : b_mag};
          neg_q  <= a_sgn ^ b_sgn;
`ifdef MULDIV_DIV_EN
          neg_r  <= a_sgn;
          dz     <= (rs2_data == '0);
`endif
        end
        BUSY: begin
          p_q   <= p_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last) result <= res_fin;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random + directed scoreboard bench for muldiv_unit.
// Expected results come from a plain-arithmetic RV32M model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, wr_en;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic prev_wr = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cap;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .funct3(funct3), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .wr_en(wr_en),
    .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb2;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    r   = '0;
    case (f)
      3'b000: begin p = sa * sb2; r = p[31:0]; end
      3'b001: begin p = sa * sb2; r = p[63:32]; end
      3'b010: begin
        p = sa * longint'({32'b0, b}); r = p[63:32];
      end
      3'b011: begin
        p = {32'b0, a} * {32'b0, b}; r = p[63:32];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        case (f)
          3'b100:
            if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
              r = 32'h80000000;
            else r = ia / ib;
          3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
          3'b110:
            if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
              r = 0;
            else r = ia % ib;
          default: r = (b == 0) ? a : a % b;
        endcase
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (wr_en) begin
        wr_cnt++;
        check("wr_single", longint'(prev_wr), 0);
        if (sb.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", longint'(result), longint'(e.res));
          check("rd_out", longint'(rd_out), longint'(e.rd));
          check("latency", longint'(cyc - e.cap), 32);
          check("done", longint'(done), 1);
        end
      end
      prev_wr = wr_en;
    end
  end

  task automatic issue(logic [2:0] f, logic [31:0] a,
                       logic [31:0] b, logic [4:0] rd);
    exp_t e;
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("issue_timeout", 1, 0);
      return;
    end
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept", longint'(busy), 1);
    e.res = ref_model(f, a, b);
    e.rd  = rd;
    e.cap = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", longint'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int w0;
    reset    = 1'b0;
    start    = 1'b1;
    funct3   = 3'b000;
    rs1_data = 32'd99;
    rs2_data = 32'd3;
    rd_in    = 5'd7;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_wr_en", longint'(wr_en), 0);
    check("rst_rd_out", longint'(rd_out), 0);
    check("rst_result", longint'(result), 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    issue(3'b000, 32'd7, 32'd6, 5'd5);
    issue(3'b001, 32'h80000000, 32'h80000000, 5'd1);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    issue(3'b010, 32'hFFFFFFFE, 32'h00000003, 5'd4);
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6);
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd8);
    issue(3'b101, 32'h12345678, 32'd0, 5'd10);
    issue(3'b110, 32'd13, 32'd0, 5'd11);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13);
    issue(3'b100, 32'd10, 32'd2, 5'd14);
    issue(3'b111, 32'd100, 32'd7, 5'd15);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin
          a = $urandom_range(0, 100);
          b = $urandom_range(0, 10);
        end
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      issue(f, a, b, 5'($urandom));
    end
    drain();

    w0 = wr_cnt;
    issue(3'b000, 32'd123, 32'd456, 5'd9);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
      start    = 1'b1;
      funct3   = 3'($urandom);
      rs1_data = $urandom;
      rs2_data = $urandom;
      rd_in    = 5'($urandom);
    end
    issue(3'b011, 32'hDEADBEEF, 32'h12345678, 5'd17);
    drain();
    check("flood_wr_count", longint'(wr_cnt - w0), 2);

    issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check("arst_result", longint'(result), 0);
    check("arst_rd_out", longint'(rd_out), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    w0 = wr_cnt;
    repeat (40) @(posedge clk);
    check("no_wr_after_rst", longint'(wr_cnt - w0), 0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    issue(3'b000, 32'hFFFFFFFF, 32'd5, 5'd31);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation; accepted only in IDLE.
REQ-005 The block SHALL have port funct3, input, 3 bits: RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port rs1_data, input, 32 bits: register file read_data1 (multiplicand or dividend).
REQ-007 The block SHALL have port rs2_data, input, 32 bits: register file read_data2 (multiplier or divisor).
REQ-008 The block SHALL have port rd_in, input, 5 bits: destination register index.
REQ-009 The block SHALL have port busy, output, 1 bit: high in BUSY and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-011 The block SHALL have port wr_en, output, 1 bit: register file write enable; equal to done.
REQ-012 The block SHALL have port rd_out, output, 5 bits: latched rd_in; drives register file rd.
REQ-013 The block SHALL have port result, output, 32 bits: registered result; drives register file wr_data.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 In IDLE with start=1 at edge N, the block SHALL latch funct3, rs1_data, rs2_data and rd_in, clear the iteration counter and enter BUSY.
REQ-016 In BUSY, each edge SHALL perform one iteration: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 After exactly 32 iterations, at edge N+32, the block SHALL register result and enter DONE.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE at edge N+33.
REQ-019 Latency SHALL be fixed at 32 cycles from the capture edge to done for every op, including special cases.
REQ-020 start SHALL be ignored in BUSY and DONE, and input changes after capture SHALL have no effect.
REQ-021 A new start SHALL be accepted in the IDLE cycle immediately following DONE.
REQ-022 MUL SHALL return the low 32 bits of the product; MULH, MULHSU and MULHU SHALL return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-023 DIV and REM SHALL operate on magnitudes, with the quotient sign equal to sign(rs1) XOR sign(rs2) and the remainder sign equal to sign(rs1); DIVU and REMU SHALL be unsigned.
REQ-024 On divide by zero, DIV and DIVU SHALL return 0xFFFFFFFF, and REM and REMU SHALL return rs1.
REQ-025 On signed overflow (0x80000000 / 0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-026 result and rd_out SHALL hold their values from DONE until the next capture.

Reset
REQ-027 When reset=0, the block SHALL enter IDLE immediately, regardless of the clock, including mid-operation.
REQ-028 During reset, busy, done, wr_en, rd_out, result, the counter and all operand registers SHALL be 0.
REQ-029 An operation interrupted by reset SHALL be discarded, with no wr_en pulse after release.
REQ-030 The first edge with reset=1 SHALL be able to accept start.

Configuration
REQ-031 With macro MULDIV_DIV_EN defined, all eight ops SHALL be implemented.
REQ-032 Without MULDIV_DIV_EN, the divider datapath SHALL be absent.
REQ-033 Without MULDIV_DIV_EN, funct3 100-111 SHALL still complete with the 32-cycle latency, with result 0 and wr_en pulsed.

Verification
REQ-034 Bench SHALL cover MUL: rs1=7, rs2=6, rd_in=5 -> done 32 cycles after capture, result=42, rd_out=5, wr_en single-cycle.
REQ-035 Bench SHALL cover MULH: rs1=0x80000000, rs2=0x80000000 -> result=0x40000000; MULHU of 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 Bench SHALL cover DIV and REM: rs1=-7 (0xFFFFFFF9), rs2=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF.
REQ-037 Bench SHALL cover special cases: DIVU x/0 -> 0xFFFFFFFF; REM 13/0 -> 13; DIV 0x80000000/-1 -> 0x80000000; without MULDIV_DIV_EN, DIV 10/2 -> 0.
REQ-038 Bench SHALL assert start on every cycle with changing operands during BUSY -> exactly one done, carrying the first captured operands; a back-to-back start in the IDLE cycle after DONE is accepted.
REQ-039 Bench SHALL drive reset=0 at iteration 10 -> busy=0 and result=0 immediately, and no wr_en pulse for 40 cycles after release.
